bpsk_demod: RTL and testbench

- Coherent BPSK receiver back-end: multiplies received baseband/IF samples by the locally generated carrier, integrates over one symbol period (integrate-and-dump), and slices the sign into a recovered bit.
- Sits downstream of the ADC/sample source and alongside the local quarter-wave carrier generator, which supplies two's-complement carrier samples in lockstep with a symbol-start marker.
- Mapping mirrors the modulator: +carrier = bit 0, inverted carrier = bit 1.

---
 rtl/bpsk_demod.sv | 97 +++++++++
 tb/tb_bpsk_demod.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_demod.sv
// Coherent BPSK integrate-and-dump demodulator.
// Each received sample is multiplied by the local carrier. The products are summed
// over one symbol, and the sign of the sum becomes the recovered bit.
// A positive sum gives bit 0 and a negative sum gives bit 1.
//
// state | meaning
// ------+---------------------------------------------------------------
// HUNT  | no symbol timing yet; samples are ignored until a sym_start arrives
// INTEG | integrating; cnt counts the samples already folded into acc
module bpsk_demod #(
    parameter int WIDTH  = 16,
    parameter int NUM    = 2,
    parameter int CYCLES = 1,
    localparam int SPB   = 4 * NUM * CYCLES,
    localparam int ACC_W = 2 * WIDTH + $clog2(SPB) + 1
) (
    input  logic                    clk_sig,
    input  logic                    rst_n,
    input  logic                    sample_en,
    input  logic signed [WIDTH-1:0] rx_sig,
    input  logic signed [WIDTH-1:0] carrier_sig,
    input  logic                    sym_start,
    output logic                    bit_sig,
    output logic                    bit_valid,
    output logic [ACC_W-1:0]        acc_sig,
    output logic                    sync_sig,
    output logic                    err_sig
);

    localparam int CNT_W = $clog2(SPB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPB - 1);

    typedef enum logic {HUNT, INTEG} state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   sum;

    // Full-precision product, sign-extended to the accumulator width; running sum incl. this sample
    always_comb begin
        prod     = rx_sig * carrier_sig;
        prod_ext = $signed({{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod});
        sum      = acc + prod_ext;
    end

    // Symbol-timing FSM with integrate-and-dump and registered outputs
    always_ff @(posedge clk_sig) begin
        if (!rst_n) begin
            state     <= HUNT;
            acc       <= '0;
            cnt       <= '0;
            bit_sig   <= 1'b0;
            bit_valid <= 1'b0;
            acc_sig   <= '0;
            sync_sig  <= 1'b0;
            err_sig   <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            err_sig   <= 1'b0;
            if (sample_en) begin
                case (state)
                    HUNT: begin
                        if (sym_start) begin
                            acc      <= prod_ext;
                            cnt      <= CNT_W'(1);
                            sync_sig <= 1'b1;
                            state    <= INTEG;
                        end
                    end
                    INTEG: begin
                        // A slip outranks a dump: the partial symbol is dropped and not sliced
                        if (sym_start && cnt != '0) begin
                            err_sig <= 1'b1;
                            acc     <= prod_ext;
                            cnt     <= CNT_W'(1);
                        end else if (cnt == CNT_LAST) begin
                            acc_sig   <= sum;
                            bit_sig   <= sum[ACC_W-1];
                            bit_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bpsk_demod.sv
// Scoreboard bench for bpsk_demod.
// The reference model keeps the products of the current symbol in a queue.
// It predicts each recovered bit, its soft value and its output cycle, and each slip pulse.
module tb_bpsk_demod;

    localparam int WIDTH  = 16;
    localparam int NUM    = 2;
    localparam int CYCLES = 1;
    localparam int SPB    = 4 * NUM * CYCLES;
    localparam int ACC_W  = 2 * WIDTH + $clog2(SPB) + 1;

    logic                    clk_sig = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    sample_en = 1'b0;
    logic signed [WIDTH-1:0] rx_sig = '0;
    logic signed [WIDTH-1:0] carrier_sig = '0;
    logic                    sym_start = 1'b0;
    logic                    bit_sig;
    logic                    bit_valid;
    logic [ACC_W-1:0]        acc_sig;
    logic                    sync_sig;
    logic                    err_sig;

    bpsk_demod #(.WIDTH(WIDTH), .NUM(NUM), .CYCLES(CYCLES)) dut (
        .clk_sig     (clk_sig),
        .rst_n       (rst_n),
        .sample_en   (sample_en),
        .rx_sig      (rx_sig),
        .carrier_sig (carrier_sig),
        .sym_start   (sym_start),
        .bit_sig     (bit_sig),
        .bit_valid   (bit_valid),
        .acc_sig     (acc_sig),
        .sync_sig    (sync_sig),
        .err_sig     (err_sig)
    );

    always #5 clk_sig = ~clk_sig;

    int cyc = 0;
    always @(posedge clk_sig) cyc <= cyc + 1;

    typedef struct {
        bit     b;
        longint acc;
        int     c;
    } bit_exp_t;

    bit_exp_t bq[$];
    int       eq[$];
    int       n_cmp = 0;
    int       n_bad = 0;

    bit       m_sync = 1'b0;
    longint   m_prod[$];
    bit       hold_b = 1'b0;
    longint   hold_acc = 0;

    int car_t[SPB] = '{0, 100, 200, 100, 0, -100, -200, -100};

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: one call per driven cycle
    task automatic model(input bit en, input logic signed [WIDTH-1:0] rx,
                         input logic signed [WIDTH-1:0] car, input bit ss, input bit rn, input int c);
        longint   p;
        longint   s;
        bit_exp_t e;
        p = longint'(rx) * longint'(car);
        if (!rn) begin
            m_sync = 1'b0;
            m_prod = {};
        end else if (en) begin
            if (!m_sync) begin
                if (ss) begin
                    m_sync = 1'b1;
                    m_prod = {p};
                end
            end else if (ss && m_prod.size() != 0) begin
                eq.push_back(c);
                m_prod = {p};
            end else begin
                m_prod.push_back(p);
                if (m_prod.size() == SPB) begin
                    s = 0;
                    foreach (m_prod[i]) s += m_prod[i];
                    e.b   = (s < 0);
                    e.acc = s;
                    e.c   = c;
                    bq.push_back(e);
                    m_prod = {};
                end
            end
        end
    endtask

    task automatic step(input bit en, input logic signed [WIDTH-1:0] rx,
                        input logic signed [WIDTH-1:0] car, input bit ss, input bit rn = 1'b1);
        @(negedge clk_sig);
        rst_n       = rn;
        sample_en   = en;
        rx_sig      = rx;
        carrier_sig = car;
        sym_start   = ss;
        model(en, rx, car, ss, rn, cyc + 1);
        @(posedge clk_sig);
        #1;
        check("sync_sig", {63'd0, sync_sig}, {63'd0, m_sync});
        if (!rn) begin
            hold_b   = 1'b0;
            hold_acc = 0;
            check("rst_bit_sig", {63'd0, bit_sig}, 64'sd0);
            check("rst_bit_valid", {63'd0, bit_valid}, 64'sd0);
            check("rst_err_sig", {63'd0, err_sig}, 64'sd0);
            check("rst_acc_sig", $signed(acc_sig), 64'sd0);
        end
    endtask

    // One symbol of (sign * reference carrier); optional idle cycle before each sample
    task automatic sym(input int sign, input bit gap, input int slip_at = -1, input int rst_at = -1);
        for (int i = 0; i < SPB; i++) begin
            if (gap) step(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            step(1'b1, WIDTH'(sign * car_t[i]), WIDTH'(car_t[i]), (i == 0) || (i == slip_at), i != rst_at);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a bit or a slip pulse
    always @(negedge clk_sig) begin
        bit_exp_t e;
        int       ec;
        if (bit_valid) begin
            if (bq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_bit_valid at cycle %0d: got 1, expected 0", cyc);
            end else begin
                e = bq.pop_front();
                check("bit_sig", {63'd0, bit_sig}, {63'd0, e.b});
                check("acc_sig", $signed(acc_sig), e.acc);
                check("bit_cycle", cyc, e.c);
                hold_b   = e.b;
                hold_acc = e.acc;
            end
        end else if (rst_n) begin
            check("hold_bit_sig", {63'd0, bit_sig}, {63'd0, hold_b});
            check("hold_acc_sig", $signed(acc_sig), hold_acc);
        end
        if (err_sig) begin
            if (eq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_err_sig at cycle %0d: got 1, expected 0", cyc);
            end else begin
                ec = eq.pop_front();
                check("err_cycle", cyc, ec);
            end
        end
    end

    initial begin
        int mode;
        int k;
        bit ss;
        bit rn;
        bit en;

        // Reset and directed cases
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        sym(1, 1'b0);
        sym(-1, 1'b0);
        sym(1, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
        sym(1, 1'b0);
        sym(1, 1'b1);
        sym(1, 1'b0, 3);
        sym(-1, 1'b0);
        sym(1, 1'b0, -1, 4);
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
        sym(1, 1'b0);
        sym(1, 1'b0, SPB - 1);
        sym(-1, 1'b0);
        for (int i = 0; i < SPB; i++) step(1'b1, WIDTH'(-car_t[i]), WIDTH'(car_t[i]), 1'b0);

        // Randomized traffic: gaps, free-running symbols, slips and resets
        for (int s = 0; s < 300; s++) begin
            mode = $urandom_range(0, 9);
            k    = $urandom_range(1, SPB - 1);
            for (int i = 0; i < SPB; i++) begin
                while ($urandom_range(0, 3) == 0)
                    step(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
                ss = ((i == 0) && (mode != 1)) || ((mode == 0) && (i == k));
                rn = !((mode == 2) && (i == k));
                en = 1'b1;
                step(en, WIDTH'($urandom), WIDTH'($urandom), ss, rn);
            end
        end

        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0);
        check("pending_bits", bq.size(), 0);
        check("pending_errs", eq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
